fetch_ctrl: RTL and testbench

Fetch sequencer for the multi-cycle / pipelined core. It owns the program counter and issues instruction-memory requests over a req/ack handshake. A one-entry output slot holds the fetched instruction for decode. Redirects from branch/JALR resolution flush the slot and restart fetch, and any in-flight response is discarded.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_slot.sv | 50 +++++
 rtl/fetch_ctrl.sv | 128 ++++++++++++
 tb/tb_fetch_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath width, fetch FSM states and reset constants.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StWait,
        StDrain
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~{{(XLEN-2){1'b0}}, 2'b11};
    endfunction

endpackage

// File: rtl/fetch_slot.sv
// One-entry output register between fetch and decode; holds pc, pc+4 and instruction.
module fetch_slot
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_load_pc,
    input  logic [XLEN-1:0] i_load_inst,
    input  logic            i_consume,
    input  logic            i_flush,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc4,
    output logic [XLEN-1:0] o_inst
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc4;
    logic [XLEN-1:0] r_inst;

    // Flush beats load beats consume; a load in the consume cycle keeps the slot full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_pc    <= RESET_PC;
            r_pc4   <= RESET_PC + 32'd4;
            r_inst  <= NOP_INST;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_load_pc;
            r_pc4   <= i_load_pc + 32'd4;
            r_inst  <= i_load_inst;
        end else if (i_consume) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;
    assign o_inst  = r_inst;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the pc, drives the imem req/ack handshake and fills the decode slot.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc4,
    output logic [XLEN-1:0] if_inst
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] r_drain_addr;
    logic [XLEN-1:0] w_drain_addr_nxt;
    logic            w_slot_free;
    logic            w_load;
    logic            w_flush;
    logic            w_consume;
    logic [XLEN-1:0] w_target;

    assign w_slot_free = !if_valid || id_ready;
    assign w_consume   = if_valid && id_ready;
    assign w_target    = word_align(redirect_pc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_pc         <= RESET_PC;
            r_drain_addr <= RESET_PC;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_drain_addr <= w_drain_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_drain_addr_nxt = r_drain_addr;
        imem_req         = 1'b0;
        imem_addr        = r_pc;
        w_load           = 1'b0;
        w_flush          = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_state_nxt = StFetch;
            end
            StFetch: begin
                if (redirect) begin
                    w_flush  = 1'b1;
                    w_pc_nxt = w_target;
                end else if (w_slot_free) begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        w_load   = 1'b1;
                        w_pc_nxt = r_pc + 32'd4;
                    end else begin
                        w_state_nxt = StWait;
                    end
                end
            end
            StWait: begin
                // req/addr must stay stable until ack, even across a redirect.
                imem_req = 1'b1;
                if (redirect) begin
                    w_flush  = 1'b1;
                    w_pc_nxt = w_target;
                    if (imem_ack) begin
                        w_state_nxt = StFetch;
                    end else begin
                        w_state_nxt      = StDrain;
                        w_drain_addr_nxt = r_pc;
                    end
                end else if (imem_ack) begin
                    w_load      = 1'b1;
                    w_pc_nxt    = r_pc + 32'd4;
                    w_state_nxt = StFetch;
                end
            end
            StDrain: begin
                imem_req  = 1'b1;
                imem_addr = r_drain_addr;
                if (redirect) begin
                    w_flush  = 1'b1;
                    w_pc_nxt = w_target;
                end
                if (imem_ack) begin
                    w_state_nxt = StFetch;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    fetch_slot #(
        .RESET_PC (RESET_PC)
    ) u_slot (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_load_pc   (r_pc),
        .i_load_inst (imem_rdata),
        .i_consume   (w_consume),
        .i_flush     (w_flush),
        .o_valid     (if_valid),
        .o_pc        (if_pc),
        .o_pc4       (if_pc4),
        .o_inst      (if_inst)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: handshake, back-pressure, redirect/drain, reset and pc wrap.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] if_inst;

    int n_vec;
    int n_err;

    fetch_ctrl u_dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_pc4      (if_pc4),
        .if_inst     (if_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after input changes.
    task automatic settle();
        #1;
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;

        step();
        step();
        check("rst_req",   {31'b0, imem_req}, 32'h0);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_valid", {31'b0, if_valid}, 32'h0);
        check("rst_pc",    if_pc, 32'h0);
        check("rst_pc4",   if_pc4, 32'h4);
        check("rst_inst",  if_inst, 32'h0000_0013);

        // Zero-wait memory, decode always ready.
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hA000_0000;
        settle();
        check("idle_req", {31'b0, imem_req}, 32'h0);
        step();
        check("f0_req",  {31'b0, imem_req}, 32'h1);
        check("f0_addr", imem_addr, 32'h0);
        step();
        imem_rdata = 32'hA000_0004;
        settle();
        check("f1_valid", {31'b0, if_valid}, 32'h1);
        check("f1_pc",    if_pc, 32'h0);
        check("f1_pc4",   if_pc4, 32'h4);
        check("f1_inst",  if_inst, 32'hA000_0000);
        check("f1_addr",  imem_addr, 32'h4);
        step();
        check("f2_pc",   if_pc, 32'h4);
        check("f2_inst", if_inst, 32'hA000_0004);
        check("f2_addr", imem_addr, 32'h8);

        // Two-cycle ack latency on 0x8.
        imem_ack = 1'b0;
        settle();
        check("w0_req", {31'b0, imem_req}, 32'h1);
        step();
        check("w1_valid", {31'b0, if_valid}, 32'h0);
        check("w1_req",   {31'b0, imem_req}, 32'h1);
        check("w1_addr",  imem_addr, 32'h8);
        step();
        check("w2_req",  {31'b0, imem_req}, 32'h1);
        check("w2_addr", imem_addr, 32'h8);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_0008;
        step();
        check("w3_valid", {31'b0, if_valid}, 32'h1);
        check("w3_pc",    if_pc, 32'h8);
        check("w3_pc4",   if_pc4, 32'hC);
        check("w3_inst",  if_inst, 32'hDEAD_0008);

        // Back-pressure: slot full, decode stalled.
        id_ready   = 1'b0;
        imem_rdata = 32'hBAD0_BAD0;
        settle();
        check("bp_req", {31'b0, imem_req}, 32'h0);
        step();
        check("bp_valid", {31'b0, if_valid}, 32'h1);
        check("bp_pc",    if_pc, 32'h8);
        check("bp_inst",  if_inst, 32'hDEAD_0008);
        check("bp_req2",  {31'b0, imem_req}, 32'h0);
        id_ready   = 1'b1;
        imem_rdata = 32'hC0DE_000C;
        settle();
        check("bp_rel_req",  {31'b0, imem_req}, 32'h1);
        check("bp_rel_addr", imem_addr, 32'hC);
        step();
        check("bp_ld_pc",   if_pc, 32'hC);
        check("bp_ld_inst", if_inst, 32'hC0DE_000C);

        // Redirect while waiting, no ack: drain the stale request.
        imem_ack = 1'b0;
        settle();
        check("rd_req_addr", imem_addr, 32'h10);
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        settle();
        check("rd_wait_req",  {31'b0, imem_req}, 32'h1);
        check("rd_wait_addr", imem_addr, 32'h10);
        step();
        redirect = 1'b0;
        settle();
        check("dr_req",   {31'b0, imem_req}, 32'h1);
        check("dr_addr",  imem_addr, 32'h10);
        check("dr_valid", {31'b0, if_valid}, 32'h0);
        check("dr_inst",  if_inst, 32'h0000_0013);
        step();
        check("dr2_addr", imem_addr, 32'h10);
        imem_ack   = 1'b1;
        imem_rdata = 32'h5757_5757;
        step();
        imem_ack = 1'b0;
        settle();
        check("dr_drop_valid", {31'b0, if_valid}, 32'h0);
        check("dr_new_req",    {31'b0, imem_req}, 32'h1);
        check("dr_new_addr",   imem_addr, 32'h100);

        // Redirect in the same cycle as ack in WAIT.
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        imem_ack    = 1'b1;
        imem_rdata  = 32'h1111_1111;
        settle();
        check("ra_addr", imem_addr, 32'h100);
        step();
        redirect = 1'b0;
        imem_ack = 1'b0;
        settle();
        check("ra_valid", {31'b0, if_valid}, 32'h0);
        check("ra_inst",  if_inst, 32'h0000_0013);
        check("ra_req",   {31'b0, imem_req}, 32'h1);
        check("ra_addr2", imem_addr, 32'h200);

        // Reset asserted mid-WAIT, redirect ignored in IDLE.
        step();
        check("rw_addr", imem_addr, 32'h200);
        reset = 1'b0;
        settle();
        check("rw_req_drop", {31'b0, imem_req}, 32'h0);
        check("rw_addr_rst", imem_addr, 32'h0);
        step();
        reset       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        settle();
        check("ri_req", {31'b0, imem_req}, 32'h0);
        step();
        redirect = 1'b0;
        settle();
        check("ri_req2", {31'b0, imem_req}, 32'h1);
        check("ri_addr", imem_addr, 32'h0);

        // Redirect from FETCH ignores ack; pc wraps past the top of memory.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        imem_ack    = 1'b1;
        imem_rdata  = 32'hBAD0_0000;
        settle();
        check("rf_req", {31'b0, imem_req}, 32'h0);
        step();
        redirect   = 1'b0;
        imem_rdata = 32'h0000_0077;
        settle();
        check("rf_valid", {31'b0, if_valid}, 32'h0);
        check("rf_addr",  imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_pc",   if_pc, 32'hFFFF_FFFC);
        check("wrap_pc4",  if_pc4, 32'h0);
        check("wrap_inst", if_inst, 32'h0000_0077);
        check("wrap_addr", imem_addr, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
